// File: rtl/pu_riscv_dmem_responder.sv
// Data-memory responder: the slave side of the core's dmem request port.
// Each request is accepted from IDLE and its fields are latched. The block then
// waits WAIT_STATES cycles and produces a one-cycle registered response.
// Stores write enabled byte lanes at the edge that raises dmem_ack.
// Handshake: a request is taken on a rising edge in IDLE with dmem_req=1.
// dmem_req is not looked at again until the block is back in IDLE.
// dmem_ack is high for exactly one cycle per accepted request.
// dmem_q, dmem_err and dmem_misaligned are meaningful only while dmem_ack=1,
// and they are zero at all other times.
module pu_riscv_dmem_responder #(
  parameter int               XLEN        = 64,
  parameter int               DEPTH       = 1024,
  parameter logic [XLEN-1:0]  BASE_ADDR   = '0,
  parameter int               WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [2:0]      dmem_size,
  input  logic            dmem_we,
  input  logic [XLEN-1:0] dmem_d,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_ack,
  output logic            dmem_err,
  output logic            dmem_misaligned,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int NB = XLEN / 8;
  localparam int SH = $clog2(NB);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   adr_q;
  logic [2:0]        size_q;
  logic              we_q;
  logic [XLEN-1:0]   dat_q;
  logic              ack_q, err_q, mis_q;
  logic [XLEN-1:0]   rdata_q;

  logic [XLEN-1:0]   mem [DEPTH];

  logic              borrow;
  logic [XLEN-1:0]   offset, word_off;
  logic              out_of_range, illegal_size, misaligned, err;
  logic [AW-1:0]     idx;
  logic [NB-1:0]     be_raw, be;
  logic              accept, access;

  // Decode the latched request: index, error classification and byte lanes.
  always_comb begin
    {borrow, offset} = {1'b0, adr_q} - {1'b0, BASE_ADDR};
    word_off     = offset >> SH;
    idx          = word_off[AW-1:0];
    out_of_range = borrow || (word_off >= XLEN'(DEPTH));
    illegal_size = (size_q > 3'd3) || ((size_q == 3'd3) && (XLEN == 32));
    case (size_q)
      3'd1:    misaligned = adr_q[0];
      3'd2:    misaligned = |adr_q[1:0];
      3'd3:    misaligned = |adr_q[2:0];
      default: misaligned = 1'b0;
    endcase
    // An illegal size is reported as a plain error, never as misalignment.
    misaligned = misaligned && !illegal_size;
    err        = illegal_size || misaligned || out_of_range;
    be_raw     = '0;
    for (int b = 0; b < NB; b++) be_raw[b] = (b < (1 << size_q[1:0]));
    be         = be_raw << adr_q[SH-1:0];
  end

  assign accept = (state_q == S_IDLE) && dmem_req;
  assign access = (state_q == S_RESP) && !err;

  // Next-state logic for the IDLE -> WAIT -> RESP sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dmem_req) begin
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'(WAIT_STATES - 1)) state_d = S_RESP;
        else                               cnt_d   = cnt_q + 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request fields when it is accepted; held through WAIT/RESP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      adr_q  <= '0;
      size_q <= '0;
      we_q   <= 1'b0;
      dat_q  <= '0;
    end else if (accept) begin
      adr_q  <= dmem_adr;
      size_q <= dmem_size;
      we_q   <= dmem_we;
      dat_q  <= dmem_d;
    end
  end

  // Registered response, valid only in the cycle after the RESP state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= (state_q == S_RESP);
      err_q   <= (state_q == S_RESP) && err;
      mis_q   <= (state_q == S_RESP) && misaligned;
      rdata_q <= (access && !we_q) ? mem[idx] : '0;
    end
  end

  // Storage is not reset; a reset forces IDLE, so no write is pending.
  always_ff @(posedge clk) begin
    if (access && we_q) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

  assign dmem_q          = rdata_q;
  assign dmem_ack        = ack_q;
  assign dmem_err        = err_q;
  assign dmem_misaligned = mis_q;
  assign busy            = (state_q != S_IDLE);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_pu_riscv_dmem_responder.sv
// Bench for pu_riscv_dmem_responder: one instance with 1 wait state and one with 4.
// Both instances share the data inputs; each has its own req and reset.
module tb_pu_riscv_dmem_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn1, rstn4, req1, req4, we;
  logic [2:0]  size;
  logic [63:0] adr, d;
  logic [63:0] q1, q4;
  logic        ack1, err1, mis1, busy1, ack4, err4, mis4, busy4;
  logic [1:0]  st1, st4;

  pu_riscv_dmem_responder #(.XLEN(64), .DEPTH(1024), .BASE_ADDR(64'h0), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rstn(rstn1), .dmem_req(req1), .dmem_adr(adr), .dmem_size(size),
    .dmem_we(we), .dmem_d(d), .dmem_q(q1), .dmem_ack(ack1), .dmem_err(err1),
    .dmem_misaligned(mis1), .busy(busy1), .dbg_state(st1));

  pu_riscv_dmem_responder #(.XLEN(64), .DEPTH(1024), .BASE_ADDR(64'h0), .WAIT_STATES(4)) dut4 (
    .clk(clk), .rstn(rstn4), .dmem_req(req4), .dmem_adr(adr), .dmem_size(size),
    .dmem_we(we), .dmem_d(d), .dmem_q(q4), .dmem_ack(ack4), .dmem_err(err4),
    .dmem_misaligned(mis4), .busy(busy4), .dbg_state(st4));

  // ---------------- scoreboard ----------------
  logic [65:0] exp_q[$];   // {q, err, misaligned}
  int vec_cnt = 0;
  int miss    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vec_cnt++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_txn(input string name, input bit sel4, input logic w, input logic [2:0] sz,
                         input logic [63:0] a, input logic [63:0] dd,
                         input logic [63:0] eq, input logic ee, input logic em);
    int lat, busy_n, ws;
    bit quiet_ok, got;
    logic [65:0] e;
    ws = sel4 ? 4 : 1;
    @(negedge clk);
    we = w; size = sz; adr = a; d = dd;
    if (sel4) req4 = 1'b1; else req1 = 1'b1;
    exp_q.push_back({eq, ee, em});
    @(negedge clk);
    req1 = 1'b0; req4 = 1'b0;
    got = 0; busy_n = 0; quiet_ok = 1; lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (sel4 ? busy4 : busy1) busy_n++;
      if (sel4 ? ack4 : ack1) begin lat = k; got = 1; break; end
      if ((sel4 ? {q4, err4, mis4} : {q1, err1, mis1}) != 66'd0) quiet_ok = 0;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    if (!got) begin
      vec_cnt++; miss++;
      $display("FAIL %s ack_timeout: no ack within 40 cycles, expected one", name);
    end else begin
      check({name, " q"}, sel4 ? q4 : q1, e[65:2]);
      check({name, " err_mis"}, 64'({sel4 ? err4 : err1, sel4 ? mis4 : mis1}), 64'(e[1:0]));
      check({name, " latency"}, 64'(lat), 64'(2 + ws));
      check({name, " busy_cycles"}, 64'(busy_n), 64'(1 + ws));
      check({name, " quiet_before_ack"}, 64'(quiet_ok), 64'd1);
      @(negedge clk);
      check({name, " ack_pulse"}, 64'(sel4 ? ack4 : ack1), 64'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [63:0] adr;
    logic [63:0] d;
    logic [63:0] q;
    logic        err;
    logic        mis;
  } vec_t;
  vec_t vecs[18];

  logic [63:0] m[8];
  logic [63:0] v;
  bit ack_seen, busy_seen;

  initial begin
    vecs[0]  = '{1'b1, 3'd3, 64'h10,   64'h1122334455667788, 64'h0,                1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'd3, 64'h10,   64'h0,                64'h1122334455667788, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'd0, 64'h13,   64'h00000000AA000000, 64'h0,                1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'd3, 64'h10,   64'h0,                64'h11223344AA667788, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd2, 64'h12,   64'h0,                64'h0,                1'b1, 1'b1};
    vecs[5]  = '{1'b0, 3'd3, 64'h10,   64'h0,                64'h11223344AA667788, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd3, 64'h2000, 64'h0,                64'h0,                1'b1, 1'b0};
    vecs[7]  = '{1'b0, 3'd5, 64'h10,   64'h0,                64'h0,                1'b1, 1'b0};
    vecs[8]  = '{1'b1, 3'd1, 64'h16,   64'hBEEF000000000000, 64'h0,                1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd3, 64'h10,   64'h0,                64'hBEEF3344AA667788, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 3'd2, 64'h11,   64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b1, 1'b1};
    vecs[11] = '{1'b1, 3'd2, 64'h14,   64'hCAFEBABE00000000, 64'h0,                1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'd3, 64'h10,   64'h0,                64'hCAFEBABEAA667788, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 3'd3, 64'h1FF8, 64'h0123456789ABCDEF, 64'h0,                1'b0, 1'b0};
    vecs[14] = '{1'b0, 3'd3, 64'h1FF8, 64'h0,                64'h0123456789ABCDEF, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 3'd3, 64'h2000, 64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b1, 1'b0};
    vecs[16] = '{1'b0, 3'd1, 64'h2001, 64'h0,                64'h0,                1'b1, 1'b1};
    vecs[17] = '{1'b0, 3'd0, 64'h13,   64'h0,                64'hCAFEBABEAA667788, 1'b0, 1'b0};

    rstn1 = 1'b0; rstn4 = 1'b0; req1 = 1'b0; req4 = 1'b0;
    we = 1'b0; size = 3'd0; adr = '0; d = '0;

    // reset state of both instances
    @(negedge clk);
    check("rst q1", q1, 64'h0);
    check("rst flags1", 64'({ack1, err1, mis1, busy1, st1}), 64'h0);
    check("rst q4", q4, 64'h0);
    check("rst flags4", 64'({ack4, err4, mis4, busy4, st4}), 64'h0);

    // a request held during reset must not be taken
    req1 = 1'b1; adr = 64'h10; size = 3'd3;
    @(negedge clk); @(negedge clk);
    rstn1 = 1'b1; rstn4 = 1'b1; req1 = 1'b0;
    ack_seen = 0; busy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack1) ack_seen = 1;
      if (busy1) busy_seen = 1;
    end
    check("req_in_reset ack", 64'(ack_seen), 64'd0);
    check("req_in_reset busy", 64'(busy_seen), 64'd0);

    // table vectors on the 1-wait-state instance
    for (int i = 0; i < 18; i++)
      run_txn($sformatf("vec%0d", i), 1'b0, vecs[i].we, vecs[i].size, vecs[i].adr,
              vecs[i].d, vecs[i].q, vecs[i].err, vecs[i].mis);

    // random byte/half-word lane traffic against a small reference model
    for (int i = 0; i < 8; i++) begin
      v = {$urandom, $urandom};
      run_txn("rnd_init", 1'b0, 1'b1, 3'd3, 64'h100 + 64'(i * 8), v, 64'h0, 1'b0, 1'b0);
      m[i] = v;
    end
    for (int n = 0; n < 24; n++) begin
      int i, op, o;
      i  = $urandom_range(0, 7);
      op = $urandom_range(0, 2);
      v  = {$urandom, $urandom};
      if (op == 0) begin
        o = $urandom_range(0, 7);
        run_txn("rnd_sb", 1'b0, 1'b1, 3'd0, 64'h100 + 64'(i * 8 + o), v, 64'h0, 1'b0, 1'b0);
        m[i][8*o +: 8] = v[8*o +: 8];
      end else if (op == 1) begin
        o = 2 * $urandom_range(0, 3);
        run_txn("rnd_sh", 1'b0, 1'b1, 3'd1, 64'h100 + 64'(i * 8 + o), v, 64'h0, 1'b0, 1'b0);
        m[i][8*o +: 16] = v[8*o +: 16];
      end else begin
        run_txn("rnd_ld", 1'b0, 1'b0, 3'd3, 64'h100 + 64'(i * 8), 64'h0, m[i], 1'b0, 1'b0);
      end
    end

    // 4-wait-state instance: store with req dropped after one cycle, then read back
    run_txn("ws4_st", 1'b1, 1'b1, 3'd3, 64'h20, 64'hA5A5F00D12345678, 64'h0, 1'b0, 1'b0);
    run_txn("ws4_ld", 1'b1, 1'b0, 3'd3, 64'h20, 64'h0, 64'hA5A5F00D12345678, 1'b0, 1'b0);

    // reset during WAIT aborts the store
    run_txn("rst_pre", 1'b1, 1'b1, 3'd3, 64'h30, 64'h5555AAAA5555AAAA, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    we = 1'b1; size = 3'd3; adr = 64'h30; d = 64'hDEADBEEFDEADBEEF; req4 = 1'b1;
    @(negedge clk);
    req4 = 1'b0;
    @(negedge clk);
    check("rst_mid busy_before", 64'(busy4), 64'd1);
    rstn4 = 1'b0;
    #1;
    check("rst_mid q", q4, 64'h0);
    check("rst_mid flags", 64'({ack4, err4, mis4, busy4}), 64'h0);
    @(negedge clk); @(negedge clk);
    rstn4 = 1'b1;
    ack_seen = 0; busy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack4) ack_seen = 1;
      if (busy4) busy_seen = 1;
    end
    check("rst_mid no_ack", 64'(ack_seen), 64'd0);
    check("rst_mid no_busy", 64'(busy_seen), 64'd0);
    run_txn("rst_post", 1'b1, 1'b0, 3'd3, 64'h30, 64'h0, 64'h5555AAAA5555AAAA, 1'b0, 1'b0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
    $finish;
  end

endmodule

// File: doc/pu_riscv_dmem_responder.md
Name: pu_riscv_dmem_responder

Overview:
- Data-memory responder: the slave end of the core's data-memory request interface (dmem_req/dmem_adr/dmem_ack) driven by the memory-access stage.
- Holds an internal XLEN-wide storage array and answers loads and stores with byte-lane writes.
- Inserts a programmable number of wait states.
- Flags misaligned and out-of-range accesses.
- Used as the dmem endpoint in core-level benches and in small tightly-coupled-memory configurations.

Parameters:
- XLEN, 64, data/address width in bits (32 or 64).
- DEPTH, 1024, number of XLEN-wide storage words.
- BASE_ADDR, 0, byte address of storage word 0.
- WAIT_STATES, 1, extra cycles between acceptance and response (0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- dmem_req  in  1  request valid.
- dmem_adr  in  XLEN  byte address.
- dmem_size  in  3  access size: BYTE=0, HWORD=1, WORD=2, DWORD=3 (DWORD legal only when XLEN=64).
- dmem_we  in  1  1=store, 0=load.
- dmem_d  in  XLEN  store data, lane-aligned to the address (byte k of the word on bits 8k+7:8k).
- dmem_q  out  XLEN  load data: the full storage word, not shifted.
- dmem_ack  out  1  one-cycle response pulse.
- dmem_err  out  1  error, valid with dmem_ack.
- dmem_misaligned  out  1  misalignment flag, valid with dmem_ack.
- busy  out  1  transaction in progress (state != IDLE).

Behaviour:
- Reset: clk and rstn as stated; reset is asynchronous, active-low. Asserting it forces state=IDLE, wait counter=0, and drives dmem_q=0, dmem_ack=0, dmem_err=0, dmem_misaligned=0, busy=0. Storage contents are not reset.
- States:
  - IDLE: accept when dmem_req=1. Latch adr, size, we, d. Go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: counter counts WAIT_STATES cycles, then go to RESP. dmem_req is ignored, so dropping or changing it does not affect the latched transaction.
  - RESP: dmem_ack=1 for exactly one cycle, then return to IDLE.
- Latency: request sampled at edge N; ack high in the cycle after edge N+1+WAIT_STATES. A back-to-back request is accepted at the first IDLE edge after the ack cycle, so maximum throughput is 1 transaction per 2+WAIT_STATES cycles.
- Word index: (adr-BASE_ADDR) >> log2(XLEN/8).
- Out-of-range: adr < BASE_ADDR or index >= DEPTH gives err=1, misaligned=0, no storage access.
- Misalignment:
  - HWORD with adr[0]!=0; WORD with adr[1:0]!=0; DWORD with adr[2:0]!=0.
  - Result: err=1, misaligned=1, no storage access.
  - Misalignment takes priority over out-of-range.
- Illegal size (dmem_size>3, or DWORD when XLEN=32): err=1, misaligned=0, no access.
- Byte enables: size-wide contiguous mask, shifted left by the byte offset of adr within the word.
- Store: the enabled lanes of dmem_d are written at the edge that raises dmem_ack; other lanes are preserved. dmem_q=0 on store responses.
- Load: dmem_q = storage word read at the same edge, registered with ack. On error responses dmem_q=0.
- Outside the ack cycle, dmem_q, dmem_err and dmem_misaligned are 0.
- Reset mid-transaction (in WAIT, or before the write edge): the transaction is aborted, no storage write occurs, and no ack is produced.
- Simultaneous request and reset release: no request is accepted on the edge where rstn is still low.

Test Plan:
- WAIT_STATES=1, XLEN=64: store DWORD 0x1122334455667788 @0x10, then load DWORD @0x10. Required: ack 3 cycles after each request edge, dmem_q=0x1122334455667788, err=0.
- Store BYTE 0xAA on lane 3 @0x13 over the word above, then load @0x10. Required: dmem_q=0x11223344AA667788.
- Load WORD @0x12. Required: ack with err=1, misaligned=1, dmem_q=0; a follow-up DWORD load @0x10 shows the storage unchanged.
- DEPTH=1024: load @0x2000. Required: err=1, misaligned=0. Also send dmem_size=5. Required: err=1, misaligned=0.
- WAIT_STATES=4: store @0x20, dropping dmem_req after 1 cycle. Required: ack exactly 6 cycles after acceptance, busy high for 5 cycles, data written.
- Store @0x30 with rstn pulsed low during WAIT. Required: no ack, all outputs 0, busy=0; a subsequent load @0x30 returns the prior contents.
